// File: rtl/tile_pkg.sv
// Shared sizing helpers and types for the tile row packer.
// Package localparams give the default geometry; modules derive their own from parameters.
package tile_pkg;

  localparam int unsigned DEF_SIZE_OF_INPUT   = 16;
  localparam int unsigned DEF_SIZE_OF_FEATURE = 4;
  localparam int unsigned ROW_COUNT_W         = 16;
  localparam int unsigned DROP_COUNT_W        = 8;

  function automatic int unsigned word_width(input int unsigned size_of_input);
    return size_of_input / 2 * 4;
  endfunction

  function automatic int unsigned row_width(input int unsigned size_of_input,
                                            input int unsigned size_of_feature);
    return word_width(size_of_input) * size_of_feature;
  endfunction

  function automatic int unsigned col_width(input int unsigned size_of_feature);
    return (size_of_feature <= 1) ? 1 : $clog2(size_of_feature);
  endfunction

  localparam int unsigned W = word_width(DEF_SIZE_OF_INPUT);
  localparam int unsigned R = row_width(DEF_SIZE_OF_INPUT, DEF_SIZE_OF_FEATURE);

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

endpackage

// File: rtl/tile_row_bank.sv
// One row-wide storage bank: per-column word write plus a full flag.
// Set has priority over clear so a single-column row refilled in the pop cycle stays full.
module tile_row_bank #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned NUM_COLS = 4,
  parameter int unsigned COL_W    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [COL_W-1:0]           col_i,
  input  logic [WORD_W-1:0]          data_i,
  input  logic                       set_full_i,
  input  logic                       clr_full_i,
  output logic [WORD_W*NUM_COLS-1:0] row_o,
  output logic                       full_o
);

  logic [WORD_W*NUM_COLS-1:0] row_q;
  logic                       full_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      row_q <= '0;
    end else if (wr_en_i) begin
      for (int unsigned k = 0; k < NUM_COLS; k++) begin
        if (col_i == COL_W'(k)) row_q[k*WORD_W +: WORD_W] <= data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          full_q <= 1'b0;
    else if (set_full_i) full_q <= 1'b1;
    else if (clr_full_i) full_q <= 1'b0;
  end

  assign row_o  = row_q;
  assign full_o = full_q;

endmodule

// File: rtl/tile_row_packer.sv
// Packs tilling-machine words into full tile rows behind a two-bank ping-pong buffer.
// No upstream backpressure: words arriving with both banks full are dropped and counted.
module tile_row_packer
  import tile_pkg::*;
#(
  parameter int unsigned SIZE_OF_INPUT   = 16,
  parameter int unsigned SIZE_OF_FEATURE = 4,
  localparam int unsigned WORD_W = word_width(SIZE_OF_INPUT),
  localparam int unsigned ROW_W  = row_width(SIZE_OF_INPUT, SIZE_OF_FEATURE)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WORD_W-1:0]       tilling_machine_i,
  input  logic                    tilling_machine_valid_i,
  output logic [ROW_W-1:0]        tile_row_o,
  output logic                    tile_row_valid_o,
  input  logic                    tile_row_ready_i,
  output logic [ROW_COUNT_W-1:0]  tile_row_count_o,
  output logic                    overflow_o,
  output logic [DROP_COUNT_W-1:0] drop_count_o
);

  localparam int unsigned COL_W = col_width(SIZE_OF_FEATURE);

  bank_e                   wr_bank, rd_bank;
  logic [COL_W-1:0]        col;
  logic [ROW_COUNT_W-1:0]  row_count;
  logic                    overflow;
  logic [DROP_COUNT_W-1:0] drop_count;

  logic [1:0]       full;
  logic [ROW_W-1:0] bank_row [2];
  logic [1:0]       wr_sel, rd_sel;
  logic [1:0]       bank_wr_en, bank_set_full, bank_clr_full;

  logic wr_full, rd_full, pop, accept, drop, last_col;

  assign wr_sel   = {wr_bank == BANK1, wr_bank == BANK0};
  assign rd_sel   = {rd_bank == BANK1, rd_bank == BANK0};
  assign wr_full  = |(full & wr_sel);
  assign rd_full  = |(full & rd_sel);
  assign last_col = (col == COL_W'(SIZE_OF_FEATURE - 1));

  // A full write bank is still writable when it is also the bank being popped this cycle.
  assign pop    = rd_full & tile_row_ready_i;
  assign accept = tilling_machine_valid_i & (~wr_full | ((wr_bank == rd_bank) & pop));
  assign drop   = tilling_machine_valid_i & ~accept;

  always_comb begin
    bank_wr_en    = '0;
    bank_set_full = '0;
    bank_clr_full = '0;
    if (accept)            bank_wr_en    = wr_sel;
    if (accept && last_col) bank_set_full = wr_sel;
    if (pop)               bank_clr_full = rd_sel;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_row_bank #(
      .WORD_W  (WORD_W),
      .NUM_COLS(SIZE_OF_FEATURE),
      .COL_W   (COL_W)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (bank_wr_en[b]),
      .col_i     (col),
      .data_i    (tilling_machine_i),
      .set_full_i(bank_set_full[b]),
      .clr_full_i(bank_clr_full[b]),
      .row_o     (bank_row[b]),
      .full_o    (full[b])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_bank <= BANK0;
      col     <= '0;
    end else if (accept) begin
      if (last_col) begin
        col     <= '0;
        wr_bank <= (wr_bank == BANK0) ? BANK1 : BANK0;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_bank   <= BANK0;
      row_count <= '0;
    end else if (pop) begin
      rd_bank   <= (rd_bank == BANK0) ? BANK1 : BANK0;
      row_count <= row_count + ROW_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_COUNT_W'(1);
    end
  end

  assign tile_row_o       = (rd_bank == BANK0) ? bank_row[0] : bank_row[1];
  assign tile_row_valid_o = rd_full;
  assign tile_row_count_o = row_count;
  assign overflow_o       = overflow;
  assign drop_count_o     = drop_count;

endmodule

// File: tb/tb_tile_row_packer.sv
// Scoreboard bench for tile_row_packer: stimulus queues expected rows, a negedge monitor checks them.
module tb_tile_row_packer;

  localparam int unsigned WW = 32;
  localparam int unsigned RW = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [WW-1:0] tilling_machine_i;
  logic          tilling_machine_valid_i;
  logic [RW-1:0] tile_row_o;
  logic          tile_row_valid_o;
  logic          tile_row_ready_i;
  logic [15:0]   tile_row_count_o;
  logic          overflow_o;
  logic [7:0]    drop_count_o;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [RW-1:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  tile_row_packer #(
    .SIZE_OF_INPUT  (16),
    .SIZE_OF_FEATURE(4)
  ) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .tilling_machine_i      (tilling_machine_i),
    .tilling_machine_valid_i(tilling_machine_valid_i),
    .tile_row_o             (tile_row_o),
    .tile_row_valid_o       (tile_row_valid_o),
    .tile_row_ready_i       (tile_row_ready_i),
    .tile_row_count_o       (tile_row_count_o),
    .overflow_o             (overflow_o),
    .drop_count_o           (drop_count_o)
  );

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every valid cycle is compared against the queue head, which also proves stability during stalls.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && tile_row_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_row actual=%h expected=none", tile_row_o);
      end else begin
        check("row_data", tile_row_o, exp_q[0]);
        if (tile_row_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    tilling_machine_valid_i = 1'b1;
    tilling_machine_i       = w;
    tick();
    tilling_machine_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    tilling_machine_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check(name, RW'(exp_q.size()), '0);
    exp_q.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WW-1:0] w [12];

    rst_i = 1'b0;
    tilling_machine_i = '0;
    tilling_machine_valid_i = 1'b0;
    tile_row_ready_i = 1'b0;
    tick();
    tick();
    check("reset_valid", RW'(tile_row_valid_o), '0);
    check("reset_row", tile_row_o, '0);
    check("reset_count", RW'(tile_row_count_o), '0);
    check("reset_overflow", RW'(overflow_o), '0);
    check("reset_drops", RW'(drop_count_o), '0);
    rst_i = 1'b1;
    tick();

    // Fill one row
    tile_row_ready_i = 1'b1;
    exp_q.push_back(128'h44444444_33333333_22222222_11111111);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    check("fill_latency_valid", RW'(tile_row_valid_o), RW'(1));
    tick();
    check("fill_count", RW'(tile_row_count_o), RW'(1));
    check("fill_valid_after_pop", RW'(tile_row_valid_o), '0);
    drain("fill_drain");

    // Streaming 400 words
    do_reset();
    tile_row_ready_i = 1'b1;
    for (int r = 0; r < 100; r++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      exp_q.push_back({w[3], w[2], w[1], w[0]});
      for (int k = 0; k < 4; k++) send_word(w[k]);
    end
    drain("stream_drain");
    check("stream_count", RW'(tile_row_count_o), RW'(100));
    check("stream_overflow", RW'(overflow_o), '0);
    check("stream_drops", RW'(drop_count_o), '0);

    // Stall: 12 words, last 4 dropped
    do_reset();
    tile_row_ready_i = 1'b0;
    for (int k = 0; k < 12; k++) w[k] = 32'hA000_0000 + 32'(k + 1);
    exp_q.push_back({w[3], w[2], w[1], w[0]});
    exp_q.push_back({w[7], w[6], w[5], w[4]});
    for (int k = 0; k < 12; k++) send_word(w[k]);
    check("stall_overflow", RW'(overflow_o), RW'(1));
    check("stall_drops", RW'(drop_count_o), RW'(4));
    check("stall_count", RW'(tile_row_count_o), '0);
    for (int k = 0; k < 3; k++) tick();
    tile_row_ready_i = 1'b1;
    drain("stall_drain");
    check("stall_count_after", RW'(tile_row_count_o), RW'(2));
    check("stall_drops_after", RW'(drop_count_o), RW'(4));

    // Coincident free: word written into the bank popped that cycle
    do_reset();
    tile_row_ready_i = 1'b0;
    for (int k = 0; k < 12; k++) w[k] = 32'hC000_0000 + 32'(k + 1);
    exp_q.push_back({w[3], w[2], w[1], w[0]});
    exp_q.push_back({w[7], w[6], w[5], w[4]});
    exp_q.push_back({w[11], w[10], w[9], w[8]});
    for (int k = 0; k < 8; k++) send_word(w[k]);
    check("coinc_valid_full", RW'(tile_row_valid_o), RW'(1));
    tile_row_ready_i = 1'b1;
    for (int k = 8; k < 12; k++) send_word(w[k]);
    drain("coinc_drain");
    check("coinc_drops", RW'(drop_count_o), '0);
    check("coinc_overflow", RW'(overflow_o), '0);
    check("coinc_count", RW'(tile_row_count_o), RW'(3));

    // Gapped input
    do_reset();
    tile_row_ready_i = 1'b1;
    exp_q.push_back(128'hDDDD0004_DDDD0003_DDDD0002_DDDD0001);
    for (int k = 0; k < 4; k++) begin
      send_word(32'hDDDD0001 + 32'(k));
      tick();
      tick();
    end
    drain("gap_drain");
    check("gap_count", RW'(tile_row_count_o), RW'(1));

    // Reset mid-row discards the partial row
    do_reset();
    tile_row_ready_i = 1'b1;
    send_word(32'hEEEE0001);
    send_word(32'hEEEE0002);
    do_reset();
    exp_q.push_back(128'hF0000004_F0000003_F0000002_F0000001);
    for (int k = 0; k < 4; k++) send_word(32'hF0000001 + 32'(k));
    drain("midrst_drain");
    check("midrst_count", RW'(tile_row_count_o), RW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
